// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared helpers for the parametrised sequence-detector FSMs
package seq_detect_pkg;

  // Widest pattern the elaboration-time transition function accepts.
  localparam int MAX_LEN = 64;

  function automatic int state_width(input int len);
    return $clog2(len + 1);
  endfunction

  // KMP-style transition: longest pattern prefix that is a suffix of
  // (first k pattern bits, a). pattern[len-1] is the first bit received.
  function automatic int next_state(input int k, input logic a,
                                    input logic [MAX_LEN-1:0] pattern,
                                    input int len, input bit overlap);
    logic [MAX_LEN:0] w;
    int               n;
    int               res;
    bit               ok;
    if (k == len && !overlap)
      return (a == pattern[len-1]) ? 1 : 0;
    w = '0;
    for (int i = 0; i < k; i++)
      w[i] = pattern[len-1-i];
    w[k] = a;
    n    = k + 1;
    res  = 0;
    for (int j = 1; j <= n && j <= len; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (w[n-j+i] != pattern[len-1-i]) ok = 1'b0;
      if (ok) res = j;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// rtl/seq_next_state.sv - combinational transition function (sp, a) -> next matched-bit count
module seq_next_state
  import seq_detect_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             SW      = state_width(LEN)
) (
  input  logic [SW-1:0] sp,
  input  logic          a,
  output logic [SW-1:0] nxt
);

  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);
  localparam logic [SW-1:0]      LAST    = SW'(LEN);

  logic [SW-1:0] tbl [0:LEN][0:1];

  // Every entry is a constant; the table folds away into plain logic.
  for (genvar k = 0; k <= LEN; k++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_a
      assign tbl[k][b] = SW'(next_state(k, 1'(b), PAT_EXT, LEN, OVERLAP));
    end
  end

  always_comb begin
    nxt = '0;
    if (sp <= LAST) nxt = tbl[sp][a];
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - Moore sequence detector with enable, sync clear and saturating match count
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = state_width(LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic             Q,
  output logic [SW-1:0]    SP,
  output logic [SW-1:0]    SF,
  output logic [CNT_W-1:0] count
);

  localparam logic [SW-1:0] FULL = SW'(LEN);

  logic [SW-1:0] delta;

  seq_next_state #(
    .LEN     (LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_next (
    .sp  (SP),
    .a   (A),
    .nxt (delta)
  );

  always_comb begin
    SF = '0;
    if (clr || SP > FULL) SF = '0;
    else if (B)           SF = delta;
    else                  SF = SP;
  end

  // Q is registered alongside SP so it always equals (SP == LEN).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SP    <= '0;
      Q     <= 1'b0;
      count <= '0;
    end else if (clr) begin
      SP    <= '0;
      Q     <= 1'b0;
      count <= '0;
    end else if (B) begin
      SP <= SF;
      Q  <= (SF == FULL);
      if (SF == FULL && count != '1) count <= count + 1'b1;
    end
  end

endmodule
